axis_burst_argmax: RTL



---
 rtl/axis_burst_argmax.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/axis_burst_argmax.sv
`default_nettype none
//==============================================================================
// Module      : axis_burst_argmax
// Description : Per-burst, per-channel peak locator. Computes |I|+|Q| for
//               every complex sample of a fixed-length AXI-stream burst,
//               tracks the first occurrence of the largest magnitude per
//               channel and emits one summary beat per burst carrying the
//               peak index/magnitude per lane, a sequence number and a
//               framing-error flag.
// Revision    : 1.0 - initial release
//==============================================================================
module axis_burst_argmax #(
    parameter int NUM_CHANNELS  = 4,
    parameter int CHANNEL_WIDTH = 32,
    parameter int BURST_LENGTH  = 32,
    parameter int SEQ_WIDTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata,
    input  logic                                  s_axis_tlast,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] m_axis_tdata,
    output logic [SEQ_WIDTH-1:0]                  m_axis_tseq,
    output logic                                  m_axis_terr
);

    localparam int HW          = CHANNEL_WIDTH / 2;
    localparam int MAG_WIDTH   = HW + 1;
    localparam int COUNT_WIDTH = $clog2(BURST_LENGTH);

    // Index of the final beat of a correctly framed burst
    localparam logic [COUNT_WIDTH-1:0] c_last_idx = COUNT_WIDTH'(BURST_LENGTH - 1);

    // Beat position and burst sequence state
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [SEQ_WIDTH-1:0]   r_seq;

    // Running per-lane peak trackers
    logic [NUM_CHANNELS-1:0][MAG_WIDTH-1:0]   r_max_mag;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] r_max_idx;

    // Registered summary beat
    logic                                  r_m_tvalid;
    logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] r_m_tdata;
    logic [SEQ_WIDTH-1:0]                  r_m_tseq;
    logic                                  r_m_terr;

    // Combinational per-beat results
    logic                                     w_accept;
    logic                                     w_first;
    logic                                     w_last_pos;
    logic                                     w_close;
    logic [NUM_CHANNELS-1:0][MAG_WIDTH-1:0]   w_mag;
    logic [NUM_CHANNELS-1:0]                  w_take;
    logic [NUM_CHANNELS-1:0][MAG_WIDTH-1:0]   w_new_mag;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] w_new_idx;
    logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]    w_summary;

    // Input only stalls while a summary is held and not being read
    assign s_axis_tready = ~r_m_tvalid | m_axis_tready;
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_first       = (r_cnt == '0);
    assign w_last_pos    = (r_cnt == c_last_idx);
    // Either an early tlast or reaching the final position closes the burst
    assign w_close       = w_accept & (s_axis_tlast | w_last_pos);

    for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_lane
        logic [HW-1:0] w_i;
        logic [HW-1:0] w_q;
        logic [HW-1:0] w_abs_i;
        logic [HW-1:0] w_abs_q;

        assign w_i = s_axis_tdata[n*CHANNEL_WIDTH      +: HW];
        assign w_q = s_axis_tdata[n*CHANNEL_WIDTH + HW +: HW];

        // Two's-complement negate; the most negative value maps to 2^(HW-1),
        // which still fits as an unsigned HW-bit number
        assign w_abs_i = w_i[HW-1] ? (~w_i + HW'(1)) : w_i;
        assign w_abs_q = w_q[HW-1] ? (~w_q + HW'(1)) : w_q;

        assign w_mag[n] = {1'b0, w_abs_i} + {1'b0, w_abs_q};

        // Beat 0 loads unconditionally; later beats need a strictly larger
        // magnitude so the earliest index wins ties
        assign w_take[n]    = w_first | (w_mag[n] > r_max_mag[n]);
        assign w_new_mag[n] = w_take[n] ? w_mag[n] : r_max_mag[n];
        assign w_new_idx[n] = w_take[n] ? r_cnt    : r_max_idx[n];

        // Lane layout: magnitude in the low bits, index above, zero fill
        assign w_summary[n*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
            CHANNEL_WIDTH'({w_new_idx[n], w_new_mag[n]});
    end

    // Beat counter: advances per accepted beat, returns to 0 on every close
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_close) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + COUNT_WIDTH'(1);
            end
        end
    end

    // Peak trackers follow every accepted beat, including the closing one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_mag <= '0;
            r_max_idx <= '0;
        end else if (w_accept) begin
            r_max_mag <= w_new_mag;
            r_max_idx <= w_new_idx;
        end
    end

    // Summary register and sequence counter; a close in the same cycle as a
    // read reloads the register so valid stays high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tseq   <= '0;
            r_m_terr   <= 1'b0;
            r_seq      <= '0;
        end else if (w_close) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_summary;
            r_m_tseq   <= r_seq;
            r_m_terr   <= s_axis_tlast ^ w_last_pos;
            r_seq      <= r_seq + SEQ_WIDTH'(1);
        end else if (r_m_tvalid && m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tseq   = r_m_tseq;
    assign m_axis_terr   = r_m_terr;

endmodule
`default_nettype wire
